// File: rtl/slider_key_ctrl.sv
// slider_key_ctrl: debounced push-button to slider move-strobe controller with auto-repeat
// Ports:
//   iVGA_CLK      - single clock, rising edge
//   iRST_n        - asynchronous active-low reset
//   iKEY[3:0]     - raw active-low buttons: [0]=go [1]=back [2]=up [3]=down
//   oSlider_*     - registered one-cycle move strobes, opposing keys on an axis cancel
//   oKey_state    - registered debounced pressed levels, active-high
module slider_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 250000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic [3:0] iKEY,
    output logic       oSlider_go,
    output logic       oSlider_back,
    output logic       oSlider_up,
    output logic       oSlider_down,
    output logic [3:0] oKey_state
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [3:0] sync1_q, sync2_q, samp_q, level_q, raw, strobe_q, mask;

    // Inversion happens ahead of the synchronizer so reset loads the released level.
    // The extra sample stage sets the press-to-strobe latency at 4+DEBOUNCE_CYCLES.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
        end else begin
            sync1_q <= ~iKEY;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
        end
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_key
            logic [DW-1:0] db_q, db_d;
            logic          lvl_q, lvl_d;
            state_t        state_q, state_d;
            logic [RW-1:0] rc_q, rc_d;
            logic          raw_k;

            // Counter only advances on samples differing from the accepted level,
            // so any agreeing sample wipes out a partial glitch.
            always_comb begin
                db_d  = '0;
                lvl_d = lvl_q;
                if (samp_q[k] != lvl_q) begin
                    if (db_q == DW'(DEBOUNCE_CYCLES)) lvl_d = ~lvl_q;
                    else                              db_d  = db_q + 1'b1;
                end
            end

            always_comb begin
                state_d = state_q;
                rc_d    = rc_q;
                raw_k   = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (lvl_q) begin
                            raw_k   = 1'b1;
                            rc_d    = RW'(REPEAT_DELAY - 1);
                            state_d = HOLD;
                        end
                    end
                    HOLD, REPEAT: begin
                        if (!lvl_q) begin
                            rc_d    = '0;
                            state_d = IDLE;
                        end else if (rc_q == '0) begin
                            raw_k   = 1'b1;
                            rc_d    = RW'(REPEAT_PERIOD - 1);
                            state_d = REPEAT;
                        end else begin
                            rc_d = rc_q - 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    db_q    <= '0;
                    lvl_q   <= 1'b0;
                    state_q <= IDLE;
                    rc_q    <= '0;
                end else begin
                    db_q    <= db_d;
                    lvl_q   <= lvl_d;
                    state_q <= state_d;
                    rc_q    <= rc_d;
                end
            end

            assign level_q[k] = lvl_q;
            assign raw[k]     = raw_k;
        end
    endgenerate

    // Opposing keys on one axis cancel each other; the other axis is unaffected.
    assign mask = {{2{~(level_q[2] & level_q[3])}}, {2{~(level_q[0] & level_q[1])}}};

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) strobe_q <= '0;
        else         strobe_q <= raw & mask;
    end

    assign oSlider_go   = strobe_q[0];
    assign oSlider_back = strobe_q[1];
    assign oSlider_up   = strobe_q[2];
    assign oSlider_down = strobe_q[3];
    assign oKey_state   = level_q;
endmodule

// File: tb/tb_slider_key_ctrl.sv
// tb_slider_key_ctrl: directed checks of debounce, auto-repeat, axis masking and reset
module tb_slider_key_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key = 4'hF;
    logic       go, back, up, down;
    logic [3:0] ks;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] s_log [0:63];
    logic [3:0] k_log [0:63];
    int         idx;

    slider_key_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iKEY(key),
        .oSlider_go(go), .oSlider_back(back), .oSlider_up(up), .oSlider_down(down),
        .oKey_state(ks)
    );

    always #5 clk = ~clk;

    // Edge numbering: the first posedge inside the first capture of a test is edge 0.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_log[idx] = {down, up, back, go};
            k_log[idx] = ks;
            idx++;
        end
    endtask

    function automatic logic [63:0] col(input int b);
        logic [63:0] r = '0;
        for (int i = 0; i < idx; i++) r[i] = s_log[i][b];
        return r;
    endfunction

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        key = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idx = 0;
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({down, up, back, go} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {down, up, back, go}); end
        checks++;
        if (ks !== 4'b0) begin failures++; $display("FAIL reset_key_state got=%b exp=0000", ks); end
        do_reset();
        capture(10);
        checks++;
        if ((col(0) | col(1) | col(2) | col(3)) !== 64'd0) begin failures++; $display("FAIL idle_no_strobe got=%h exp=0", col(0) | col(1) | col(2) | col(3)); end
    endtask

    task automatic test_hold;
        logic [63:0] exp;
        do_reset();
        key = 4'b1110;
        capture(30);
        exp = (64'd1 << 8) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25) | (64'd1 << 28);
        checks++;
        if (col(0) !== exp) begin failures++; $display("FAIL hold_go got=%h exp=%h", col(0), exp); end
        checks++;
        if ((col(1) | col(2) | col(3)) !== 64'd0) begin failures++; $display("FAIL hold_others got=%h exp=0", col(1) | col(2) | col(3)); end
        checks++;
        if (k_log[6] !== 4'b0000) begin failures++; $display("FAIL hold_ks_e6 got=%b exp=0000", k_log[6]); end
        checks++;
        if (k_log[7] !== 4'b0001) begin failures++; $display("FAIL hold_ks_e7 got=%b exp=0001", k_log[7]); end
        checks++;
        if (k_log[29] !== 4'b0001) begin failures++; $display("FAIL hold_ks_e29 got=%b exp=0001", k_log[29]); end
    endtask

    task automatic test_glitch;
        logic [3:0] any_ks = '0;
        do_reset();
        key = 4'b1011;
        capture(3);
        key = 4'hF;
        capture(20);
        for (int i = 0; i < idx; i++) any_ks |= k_log[i];
        checks++;
        if (col(2) !== 64'd0) begin failures++; $display("FAIL glitch_up got=%h exp=0", col(2)); end
        checks++;
        if (any_ks !== 4'b0) begin failures++; $display("FAIL glitch_ks got=%b exp=0000", any_ks); end
    endtask

    task automatic test_release_hold;
        do_reset();
        key = 4'b1110;
        capture(6);
        key = 4'hF;
        capture(24);
        checks++;
        if (col(0) !== (64'd1 << 8)) begin failures++; $display("FAIL release_go got=%h exp=%h", col(0), 64'd1 << 8); end
        checks++;
        if (k_log[12] !== 4'b0001) begin failures++; $display("FAIL release_ks_e12 got=%b exp=0001", k_log[12]); end
        checks++;
        if (k_log[13] !== 4'b0000) begin failures++; $display("FAIL release_ks_e13 got=%b exp=0000", k_log[13]); end
    endtask

    task automatic test_conflict;
        logic [63:0] exp;
        do_reset();
        key = 4'b1110;
        capture(2);
        key = 4'b1100;
        capture(18);
        key = 4'b1110;
        capture(16);
        exp = (64'd1 << 8) | (64'd1 << 28) | (64'd1 << 31) | (64'd1 << 34);
        checks++;
        if (col(0) !== exp) begin failures++; $display("FAIL conflict_go got=%h exp=%h", col(0), exp); end
        checks++;
        if (col(1) !== 64'd0) begin failures++; $display("FAIL conflict_back got=%h exp=0", col(1)); end
        checks++;
        if (k_log[15] !== 4'b0011) begin failures++; $display("FAIL conflict_ks got=%b exp=0011", k_log[15]); end
    endtask

    task automatic test_lockstep;
        logic [63:0] exp;
        do_reset();
        key = 4'b1010;
        capture(30);
        exp = (64'd1 << 8) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25) | (64'd1 << 28);
        checks++;
        if (col(0) !== exp) begin failures++; $display("FAIL lockstep_go got=%h exp=%h", col(0), exp); end
        checks++;
        if (col(2) !== exp) begin failures++; $display("FAIL lockstep_up got=%h exp=%h", col(2), exp); end
        checks++;
        if ((col(1) | col(3)) !== 64'd0) begin failures++; $display("FAIL lockstep_others got=%h exp=0", col(1) | col(3)); end
        checks++;
        if (k_log[20] !== 4'b0101) begin failures++; $display("FAIL lockstep_ks got=%b exp=0101", k_log[20]); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        key = 4'b1110;
        capture(20);
        checks++;
        if (s_log[19] !== 4'b0001) begin failures++; $display("FAIL mid_pre_pulse got=%b exp=0001", s_log[19]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ks, down, up, back, go} !== 8'h00) begin failures++; $display("FAIL mid_async_clear got=%b exp=00000000", {ks, down, up, back, go}); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idx = 0;
        capture(14);
        checks++;
        if (col(0) !== (64'd1 << 8)) begin failures++; $display("FAIL mid_restart_go got=%h exp=%h", col(0), 64'd1 << 8); end
        checks++;
        if (k_log[0] !== 4'b0000) begin failures++; $display("FAIL mid_restart_ks got=%b exp=0000", k_log[0]); end
    endtask

    initial begin
        idx = 0;
        test_reset();
        test_hold();
        test_glitch();
        test_release_hold();
        test_conflict();
        test_lockstep();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
